// File: rtl/skid_buffer_stage.sv
// Two-entry register slice for a valid/ready stream: out reg plus skid reg, with
// in_ready, out_valid, out_data and occ all driven straight from flops.
module skid_buffer_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] out_data_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_s;
  logic             in_fire_s;
  logic             out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next-state and data-capture selection from the two handshakes.
  always_comb begin
    state_s    = state_r;
    out_data_s = out_data_r;
    skid_s     = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_fire_s) begin
          state_s    = ST_ONE;
          out_data_s = in_data;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_fire_s && !out_fire_s) begin
          state_s = ST_FULL;
          skid_s  = in_data;
        end else if (!in_fire_s && out_fire_s) begin
          state_s = ST_EMPTY;
        end else if (in_fire_s && out_fire_s) begin
          state_s    = ST_ONE;
          out_data_s = in_data;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the downstream handshake matters.
        if (out_fire_s) begin
          state_s    = ST_ONE;
          out_data_s = skid_r;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // State, payload and handshake flops; in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      skid_r      <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != ST_FULL);
      out_valid_r <= (state_s != ST_EMPTY);
      out_data_r  <= out_data_s;
      skid_r      <= skid_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign occ       = state_r;

endmodule

// File: tb/tb_skid_buffer_stage.sv
// Self-checking bench for skid_buffer_stage: directed vector table, reset corner
// cases, and random traffic checked against a queue-based FIFO model.
module tb_skid_buffer_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occ;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: contents of the slice in arrival order, plus whether it is accepting.
  logic [31:0] q[$];
  logic        m_ready;
  int          n_out;

  skid_buffer_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ready;
    logic        e_valid;
    logic [1:0]  e_occ;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_model();
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
    chk("occ", {30'd0, occ}, q.size());
    if (q.size() > 0) chk("out_data", out_data, q[0]);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check at the next negedge.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy);
    bit inf;
    bit outf;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    inf  = iv && m_ready;
    outf = (q.size() > 0) && ordy;
    @(posedge clk);
    if (outf) begin
      void'(q.pop_front());
      n_out++;
    end
    if (inf) q.push_back(id);
    m_ready = (q.size() < 2);
    @(negedge clk);
    check_model();
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] nxt;
    int          cyc;
    bit          iv;
    bit          ordy;

    vecs[0]  = '{1'b1, 32'hEE, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{1'b1, 32'hA1, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA1};
    vecs[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    vecs[3]  = '{1'b1, 32'hB2, 1'b0, 1'b1, 1'b1, 2'd1, 32'hB2};
    vecs[4]  = '{1'b1, 32'hC3, 1'b0, 1'b0, 1'b1, 2'd2, 32'hB2};
    vecs[5]  = '{1'b1, 32'hEE, 1'b0, 1'b0, 1'b1, 2'd2, 32'hB2};
    vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 2'd2, 32'hB2};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 32'hC3};
    vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    vecs[9]  = '{1'b1, 32'h1,  1'b1, 1'b1, 1'b1, 2'd1, 32'h1};
    vecs[10] = '{1'b1, 32'h2,  1'b1, 1'b1, 1'b1, 2'd1, 32'h2};
    vecs[11] = '{1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 2'd1, 32'h3};
    vecs[12] = '{1'b1, 32'h4,  1'b1, 1'b1, 1'b1, 2'd1, 32'h4};
    vecs[13] = '{1'b1, 32'h5,  1'b1, 1'b1, 1'b1, 2'd1, 32'h5};
    vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 2'd0, 32'h0};

    n_out = 0;
    model_reset();

    // Reset held five cycles with in_valid high.
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hFF; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_occ", {30'd0, occ}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd0);

    // Directed vectors: first edge after release, single beat, backpressure, stream.
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_occ", i), {30'd0, occ}, {30'd0, vecs[i].e_occ});
      if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
    end

    // Random traffic with incrementing payload until 1000 beats have been delivered.
    nxt = 32'd1000;
    n_out = 0;
    cyc = 0;
    while (n_out < 1000 && cyc < 20000) begin
      iv   = ($urandom % 2) == 1;
      ordy = ($urandom % 2) == 1;
      // Flip out_ready mid-cycle: in_ready must not react without a clock edge.
      out_ready = ~out_ready;
      #1;
      chk("in_ready_no_comb", {31'd0, in_ready}, {31'd0, m_ready});
      if (iv && m_ready) begin
        cycle(1'b1, nxt, ordy);
        nxt = nxt + 32'd1;
      end else begin
        cycle(iv, 32'hDEAD0000 | cyc, ordy);
      end
      cyc++;
    end
    chk("random_beats_delivered", n_out, 32'd1000);

    // Reset in the middle of a FULL state clears outputs without a clock edge.
    cycle(1'b1, 32'h11, 1'b0);
    cycle(1'b1, 32'h22, 1'b0);
    cycle(1'b1, 32'h33, 1'b0);
    chk("pre_rst_occ", {30'd0, occ}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_occ", {30'd0, occ}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    model_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'hD4, 1'b0);
    chk("post_rst_first_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_first_data", out_data, 32'hD4);
    cycle(1'b0, 32'h0, 1'b1);
    chk("post_rst_drain_occ", {30'd0, occ}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
